led_pattern_seq: RTL and testbench



---
 rtl/led_seq_pkg.sv | 37 +++
 rtl/led_pattern_seq_if.sv | 24 ++
 rtl/toggle_to_pulse.sv | 23 ++
 rtl/led_pattern_seq.sv | 104 ++++++++++
 tb/tb_led_pattern_seq.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and init patterns for the LED pattern sequencer.
// Optional build macro LED_SEQ_INVERT_EN (active-low LED drive) is handled in led_pattern_seq.
package led_seq_pkg;

    localparam int unsigned MAX_LED_W = 16;

    typedef enum logic [1:0] {
        MODE_BLINK  = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } led_mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    localparam logic [MAX_LED_W-1:0] INIT_BLINK  = 16'h0000;
    localparam logic [MAX_LED_W-1:0] INIT_CHASE  = 16'h0001;
    localparam logic [MAX_LED_W-1:0] INIT_BOUNCE = 16'h0001;
    localparam logic [MAX_LED_W-1:0] INIT_COUNT  = 16'h0000;

    // Init pattern at maximum width; callers truncate to their LED count.
    function automatic logic [MAX_LED_W-1:0] init_pattern(input led_mode_t mode);
        logic [MAX_LED_W-1:0] p;
        p = INIT_BLINK;
        case (mode)
            MODE_BLINK:  p = INIT_BLINK;
            MODE_CHASE:  p = INIT_CHASE;
            MODE_BOUNCE: p = INIT_BOUNCE;
            MODE_COUNT:  p = INIT_COUNT;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/led_pattern_seq_if.sv
// Board-side bundle of the LED sequencer: step source, controls and LED drive.
// master = board/control side, slave = sequencer.
interface led_pattern_seq_if #(
    parameter int unsigned LED_W = 8
);
    import led_seq_pkg::*;

    logic             div_in;
    logic             enable;
    led_mode_t        mode_i;
    logic             mode_load;
    logic [LED_W-1:0] led_o;
    logic             step_o;

    modport master (
        output div_in, enable, mode_i, mode_load,
        input  led_o, step_o
    );

    modport slave (
        input  div_in, enable, mode_i, mode_load,
        output led_o, step_o
    );
endinterface

// File: rtl/toggle_to_pulse.sv
// Armed edge detector: every transition of tog_i gives a one-cycle combinational pulse.
// The first clock after reset only captures tog_i so a reset-time level is never a step.
module toggle_to_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic tog_i,
    output logic pulse_o
);
    logic armed;
    logic tog_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
            tog_q <= 1'b0;
        end else begin
            armed <= 1'b1;
            tog_q <= tog_i;
        end
    end

    assign pulse_o = armed & (tog_i ^ tog_q);
endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: advances blink/chase/bounce/count on each divider edge.
// Define LED_SEQ_INVERT_EN for active-low LED boards (led_o = ~pattern).
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int unsigned LED_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    led_pattern_seq_if.slave     bus
);
    localparam int unsigned MSB = LED_W - 1;

    seq_state_t       state;
    led_mode_t        mode;
    led_mode_t        mode_eff;
    logic [LED_W-1:0] pat;
    logic [LED_W-1:0] pat_adv;
    logic [LED_W-1:0] pat_init;
    logic             dir_up;
    logic             dir_adv;
    logic             step;
    logic             step_q;

    toggle_to_pulse u_tog (
        .clk     (clk),
        .rst_n   (rst_n),
        .tog_i   (bus.div_in),
        .pulse_o (step)
    );

    // A coincident load takes effect on the same edge, so init uses the incoming mode.
    always_comb begin
        mode_eff = bus.mode_load ? bus.mode_i : mode;
        pat_init = LED_W'(init_pattern(mode_eff));
    end

    // Next pattern for one step; bounce flips direction on the step that lands on an end bit.
    always_comb begin
        pat_adv = pat;
        dir_adv = dir_up;
        case (mode)
            MODE_BLINK:  pat_adv = ~pat;
            MODE_CHASE:  pat_adv = {pat[LED_W-2:0], pat[MSB]};
            MODE_BOUNCE: begin
                if (dir_up) begin
                    pat_adv = pat << 1;
                    dir_adv = ~pat_adv[MSB];
                end else begin
                    pat_adv = pat >> 1;
                    dir_adv = pat_adv[0];
                end
            end
            MODE_COUNT:  pat_adv = pat + LED_W'(1);
        endcase
    end

    // Priority: enable low, then mode load, then step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mode   <= MODE_BLINK;
            pat    <= '0;
            dir_up <= 1'b1;
            step_q <= 1'b0;
        end else begin
            step_q <= 1'b0;
            if (bus.mode_load) begin
                mode <= bus.mode_i;
            end
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        state  <= RUN;
                        pat    <= pat_init;
                        dir_up <= 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.enable) begin
                        state  <= IDLE;
                        pat    <= '0;
                        dir_up <= 1'b1;
                    end else if (bus.mode_load) begin
                        pat    <= pat_init;
                        dir_up <= 1'b1;
                    end else if (step) begin
                        pat    <= pat_adv;
                        dir_up <= dir_adv;
                        step_q <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef LED_SEQ_INVERT_EN
    assign bus.led_o = ~pat;
`else
    assign bus.led_o = pat;
`endif
    assign bus.step_o = step_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq: directed steps plus random traffic
// against a phase-counting reference model.
module tb_led_pattern_seq;
    import led_seq_pkg::*;

    localparam int unsigned LED_W = 8;
    localparam int          PER   = 2 * (LED_W - 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_pattern_seq_if #(.LED_W(LED_W)) bus ();

    led_pattern_seq #(.LED_W(LED_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a pattern is a function of mode and steps taken since its init.
    bit        m_run;
    bit        m_armed;
    bit        m_prev;
    led_mode_t m_mode;
    int        m_phase;
    bit        m_step;

    function automatic logic [LED_W-1:0] pat_of(input led_mode_t md, input int ph);
        logic [LED_W-1:0] one;
        int p;
        one = LED_W'(1);
        case (md)
            MODE_BLINK:  return (ph % 2 == 1) ? '1 : '0;
            MODE_CHASE:  return one << (ph % LED_W);
            MODE_BOUNCE: begin
                p = ph % PER;
                if (p >= LED_W) p = PER - p;
                return one << p;
            end
            default:     return LED_W'(ph);
        endcase
    endfunction

    function automatic logic [LED_W-1:0] exp_led();
        logic [LED_W-1:0] v;
        v = m_run ? pat_of(m_mode, m_phase) : '0;
`ifdef LED_SEQ_INVERT_EN
        v = ~v;
`endif
        return v;
    endfunction

    task automatic model_reset();
        m_run   = 0;
        m_armed = 0;
        m_prev  = 0;
        m_mode  = MODE_BLINK;
        m_phase = 0;
        m_step  = 0;
    endtask

    task automatic model_edge();
        bit st;
        st      = m_armed && (bus.div_in != m_prev);
        m_prev  = bus.div_in;
        m_armed = 1;
        m_step  = 0;
        if (!m_run) begin
            if (bus.enable) begin
                m_run   = 1;
                m_phase = 0;
            end
        end else if (!bus.enable) begin
            m_run   = 0;
            m_phase = 0;
        end else if (bus.mode_load) begin
            m_phase = 0;
        end else if (st) begin
            m_phase++;
            m_step = 1;
        end
        if (bus.mode_load) m_mode = bus.mode_i;
    endtask

    task automatic check_out(input string tag);
        logic [LED_W-1:0] e;
        e = exp_led();
        checks++;
        assert (bus.led_o === e) else begin
            errors++;
            $error("FAIL %s led_o got %h want %h", tag, bus.led_o, e);
        end
        checks++;
        assert (bus.step_o === m_step) else begin
            errors++;
            $error("FAIL %s step_o got %b want %b", tag, bus.step_o, m_step);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_out(tag);
    endtask

    task automatic toggle();
        bus.div_in = ~bus.div_in;
    endtask

    task automatic load(input led_mode_t md, input string tag);
        bus.mode_i    = md;
        bus.mode_load = 1'b1;
        tick(tag);
        bus.mode_load = 1'b0;
    endtask

    initial begin
        bus.div_in    = 1'b1;
        bus.enable    = 1'b0;
        bus.mode_i    = MODE_BLINK;
        bus.mode_load = 1'b0;
        model_reset();
        #12;
        check_out("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick("arm_no_step");
        tick("idle_hold");
        repeat (3) begin
            toggle();
            tick("idle_discard");
        end

        bus.enable = 1'b1;
        load(MODE_CHASE, "chase_init");
        repeat (9) begin
            toggle();
            tick("chase_step");
            tick("chase_gap");
        end

        load(MODE_BOUNCE, "bounce_init");
        repeat (16) begin
            toggle();
            tick("bounce_step");
        end

        load(MODE_COUNT, "count_init");
        repeat (255) begin
            toggle();
            tick("count_run");
        end
        toggle();
        tick("count_wrap");

        toggle();
        load(MODE_BLINK, "blink_load_drops_step");
        toggle();
        tick("blink_first");
        tick("blink_gap");

        load(MODE_BOUNCE, "bounce2_init");
        repeat (10) begin
            toggle();
            tick("bounce2_step");
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_out("async_reset");
        bus.enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick("post_rst_arm");
        bus.enable = 1'b1;
        load(MODE_BOUNCE, "post_rst_bounce");
        repeat (9) begin
            toggle();
            tick("post_rst_up");
        end

        bus.enable = 1'b0;
        tick("disable");
        bus.enable = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(2, 0) == 0) toggle();
            bus.enable    = ($urandom_range(19, 0) != 0);
            bus.mode_load = ($urandom_range(14, 0) == 0);
            bus.mode_i    = led_mode_t'($urandom_range(3, 0));
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
